// File: rtl/mid_side_pkg.sv
// mid_side_pkg: shared width, mode encoding and sample type for the mid/side encoder.
package mid_side_pkg;
  localparam int DATA_W_DEFAULT = 16;
  typedef enum logic {MS_BYPASS = 1'b0, MS_ENCODE = 1'b1} ms_mode_e;
  typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;
endpackage

// File: rtl/mid_side_if.sv
// mid_side_if: sample-rate bus carrying the L/R inputs, mode, clock enable and mid/side outputs.
interface mid_side_if import mid_side_pkg::*; #(parameter int DATA_W = DATA_W_DEFAULT) ();
  logic ce;
  logic enable;
  logic signed [DATA_W-1:0] L;
  logic signed [DATA_W-1:0] R;
  logic signed [DATA_W-1:0] mid;
  logic signed [DATA_W-1:0] side;
  modport master (output ce, enable, L, R, input mid, side);
  modport slave (input ce, enable, L, R, output mid, side);
endinterface

// File: rtl/ms_butterfly.sv
// ms_butterfly: floor-halved sum and difference of two signed samples, one bit wider internally.
module ms_butterfly import mid_side_pkg::*; #(parameter int DATA_W = DATA_W_DEFAULT) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] half_sum,
  output logic signed [DATA_W-1:0] half_diff
);
  logic [DATA_W:0] sum, diff;
  assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
  // dropping the LSB of the widened result is an arithmetic shift, rounding toward -inf
  assign half_sum = sum[DATA_W:1];
  assign half_diff = diff[DATA_W:1];
endmodule

// File: rtl/mid_side_core.sv
// mid_side_core: registered stereo mid/side encoder with per-sample bypass, clock enable and sync reset.
module mid_side_core import mid_side_pkg::*; #(parameter int DATA_W = DATA_W_DEFAULT) (
  input logic clk,
  input logic rst,
  mid_side_if.slave bus
);
  ms_mode_e mode;
  logic signed [DATA_W-1:0] enc_mid, enc_side, mid_q, side_q;
  logic [DATA_W:0] ms_sum, enc_expect;
  assign mode = ms_mode_e'(bus.enable);
  ms_butterfly #(.DATA_W(DATA_W)) u_bfly (
    .a(bus.L),
    .b(bus.R),
    .half_sum(enc_mid),
    .half_diff(enc_side)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_q <= '0;
      side_q <= '0;
    end else if (bus.ce) begin
      mid_q <= (mode == MS_ENCODE) ? enc_mid : bus.L;
      side_q <= (mode == MS_ENCODE) ? enc_side : bus.R;
    end
  end
  assign bus.mid = mid_q;
  assign bus.side = side_q;
  // floor halves lose one LSB in total when L+R is odd, so mid+side == L - parity
  assign ms_sum = {mid_q[DATA_W-1], mid_q} + {side_q[DATA_W-1], side_q};
  assign enc_expect = {bus.L[DATA_W-1], bus.L} - (DATA_W+1)'(bus.L[0] ^ bus.R[0]);
  a_floor_identity: assert property (@(posedge clk)
    (!rst && bus.ce && mode == MS_ENCODE) |=> (ms_sum == $past(enc_expect)));
  a_reset_zero: assert property (@(posedge clk)
    rst |=> (mid_q == '0 && side_q == '0));
endmodule

// File: tb/tb_mid_side_core.sv
// tb_mid_side_core: directed table, hand sequences and randomized regression against a floor-division model.
module tb_mid_side_core;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int exp_mid = 0;
  int exp_side = 0;
  always #5 clk = ~clk;
  mid_side_if #(.DATA_W(16)) bus ();
  mid_side_core #(.DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string name;
    bit en;
    int l;
    int r;
    int m;
    int s;
  } vec_t;
  vec_t vecs[15];

  function automatic int floor_half(int v);
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic cyc(bit r, bit ce, bit en, int l, int rr);
    @(negedge clk);
    rst = r;
    bus.ce = ce;
    bus.enable = en;
    bus.L = 16'(l);
    bus.R = 16'(rr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string name, int m, int s);
    chk({name, "_mid"}, int'(bus.mid), m);
    chk({name, "_side"}, int'(bus.side), s);
  endtask

  initial begin
    logic [15:0] lr, rr;
    bit r, c, e;
    int l, rv;
    rst = 1'b0;
    bus.ce = 1'b0;
    bus.enable = 1'b0;
    bus.L = '0;
    bus.R = '0;
    vecs[0]  = '{"byp_a", 1'b0, 1000, 500, 1000, 500};
    vecs[1]  = '{"byp_b", 1'b0, -500, 200, -500, 200};
    vecs[2]  = '{"byp_fs", 1'b0, 32767, -32768, 32767, -32768};
    vecs[3]  = '{"enc_a", 1'b1, 2000, 1000, 1500, 500};
    vecs[4]  = '{"enc_b", 1'b1, -2000, 2000, 0, -2000};
    vecs[5]  = '{"enc_c", 1'b1, 3, 0, 1, 1};
    vecs[6]  = '{"enc_d", 1'b1, 100, -50, 25, 75};
    vecs[7]  = '{"round_neg", 1'b1, -3, 0, -2, -2};
    vecs[8]  = '{"max_max", 1'b1, 32767, 32767, 32767, 0};
    vecs[9]  = '{"min_min", 1'b1, -32768, -32768, -32768, 0};
    vecs[10] = '{"max_min", 1'b1, 32767, -32768, -1, 32767};
    vecs[11] = '{"tog_enc1", 1'b1, 10, 4, 7, 3};
    vecs[12] = '{"tog_byp", 1'b0, 10, 4, 10, 4};
    vecs[13] = '{"tog_enc2", 1'b1, 10, 4, 7, 3};
    vecs[14] = '{"min_max", 1'b1, -32768, 32767, -1, -32768};
    // reset with ce low, then load, then hold
    cyc(1, 0, 0, 123, 456);
    chk_out("rst_ce0", 0, 0);
    cyc(0, 1, 0, 5, 7);
    chk_out("load", 5, 7);
    cyc(0, 0, 1, 99, -99);
    chk_out("hold1", 5, 7);
    cyc(0, 0, 0, -1, 1);
    chk_out("hold2", 5, 7);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, vecs[i].en, vecs[i].l, vecs[i].r);
      chk_out(vecs[i].name, vecs[i].m, vecs[i].s);
    end
    // reset wins over ce and discards the sample presented with it
    cyc(1, 1, 1, 2000, 1000);
    chk_out("rst_prio", 0, 0);
    cyc(0, 1, 1, 2000, 1000);
    chk_out("post_rst", 1500, 500);
    exp_mid = 1500;
    exp_side = 500;
    for (int n = 0; n < 10000; n++) begin
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 3) != 0);
      e = 1'($urandom);
      lr = 16'($urandom);
      rr = 16'($urandom);
      l = int'($signed(lr));
      rv = int'($signed(rr));
      if (n % 997 == 0) begin
        l = (n % 2) ? 32767 : -32768;
        rv = -l - 1;
      end
      cyc(r, c, e, l, rv);
      if (r) begin
        exp_mid = 0;
        exp_side = 0;
      end else if (c) begin
        exp_mid = e ? floor_half(l + rv) : l;
        exp_side = e ? floor_half(l - rv) : rv;
      end
      chk_out("rand", exp_mid, exp_side);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
